mod_updown_counter: RTL

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

---
 rtl/mod_updown_counter_pkg.sv | 25 ++
 rtl/mod_updown_counter_digit.sv | 60 ++++++
 rtl/mod_updown_counter.sv | 61 ++++++
 3 files changed

// File: rtl/mod_updown_counter_pkg.sv
// Shared types for the cascaded modulo-RADIX up/down counter.
// Holds the digit width, the direction and digit-operation encodings, and a load clamp helper.
package mod_updown_counter_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_STEP = 2'd1,
    OP_LOAD = 2'd2
  } op_e;

  function automatic logic [DIGIT_W-1:0] clamp_digit(
    input logic [DIGIT_W-1:0] d,
    input logic [DIGIT_W-1:0] max
  );
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/mod_updown_counter_digit.sv
// counter_digit: one modulo-RADIX digit slice with load, step and carry-out.
// Ports: clk_i, rst_i, ci_i (step enable), up_i, load_i, d_i -> q_o, co_o.
module counter_digit
  import mod_updown_counter_pkg::*;
#(
  parameter int RADIX = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ci_i,
  input  logic               up_i,
  input  logic               load_i,
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] q_o,
  output logic               co_o
);

  localparam logic [DIGIT_W-1:0] MAX = DIGIT_W'(RADIX - 1);
  localparam logic [DIGIT_W-1:0] ONE = DIGIT_W'(1);

  logic [DIGIT_W-1:0] q_q;
  logic [DIGIT_W-1:0] q_d;
  dir_e               dir;
  op_e                op;

  assign dir = dir_e'(up_i);

  always_comb begin
    op = OP_HOLD;
    unique case (1'b1)
      load_i:  op = OP_LOAD;
      ci_i:    op = OP_STEP;
      default: op = OP_HOLD;
    endcase
  end

  always_comb begin
    q_d = q_q;
    unique case (op)
      OP_LOAD: q_d = clamp_digit(d_i, MAX);
      OP_STEP: begin
        if (dir == DIR_UP)
          q_d = (q_q == MAX) ? '0 : q_q + ONE;
        else
          q_d = (q_q == '0) ? MAX : q_q - ONE;
      end
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  // Terminal digit for the current direction; the top ANDs this into the chain.
  assign co_o = (dir == DIR_UP) ? (q_q == MAX) : (q_q == '0);
  assign q_o  = q_q;

endmodule

// File: rtl/mod_updown_counter.sv
// Cascaded DIGITS-digit modulo-RADIX up/down counter with load and sticky wrap.
// Ports: CLK, Reset, En, Up, Load, D, Clr_Wrap -> Q, TC (combinational), Wrap.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int RADIX  = 10
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      En,
  input  logic                      Up,
  input  logic                      Load,
  input  logic [DIGIT_W*DIGITS-1:0] D,
  input  logic                      Clr_Wrap,
  output logic [DIGIT_W*DIGITS-1:0] Q,
  output logic                      TC,
  output logic                      Wrap
);

  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] co;
  logic              wrap_q;
  logic              wrap_d;

  // Load blocks stepping, so it also masks the chain and TC.
  assign carry[0] = En & ~Load;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    counter_digit #(
      .RADIX(RADIX)
    ) u_dig (
      .clk_i (CLK),
      .rst_i (Reset),
      .ci_i  (carry[i]),
      .up_i  (Up),
      .load_i(Load),
      .d_i   (D[DIGIT_W*i +: DIGIT_W]),
      .q_o   (Q[DIGIT_W*i +: DIGIT_W]),
      .co_o  (co[i])
    );
    assign carry[i+1] = carry[i] & co[i];
  end

  assign TC = carry[DIGITS];

  // Set beats clear when both land on the same edge.
  always_comb begin
    wrap_d = wrap_q;
    if (Clr_Wrap) wrap_d = 1'b0;
    if (TC)       wrap_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (Reset) wrap_q <= 1'b0;
    else       wrap_q <= wrap_d;
  end

  assign Wrap = wrap_q;

endmodule
